// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit port bundle: PC handshake, instruction-memory request/response and decode handoff.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc_in;
  logic            pc_advance;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_fault;
  logic            if_ready;

  modport master (
    input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output pc_advance, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault
  );
  modport slave (
    output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  pc_advance, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem read, small FIFO toward decode, flush with
// in-flight discard, and misaligned-PC trap entries.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR  = 32'h00000013
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DROP, FAULT} state_t;

  state_t                           state;
  logic [AW:0]                      count;
  logic [AW-1:0]                    rd_ptr, wr_ptr, wr_next;
  logic [XLEN-1:0]                  pending_pc;
  logic [FIFO_DEPTH-1:0][XLEN-1:0]  buf_pc, buf_instr;
  logic [FIFO_DEPTH-1:0]            buf_fault;

  logic       aligned, allow, issue, fault_push, rsp_push, handshake, head_valid, pop;
  logic [1:0] n_push;

  always_comb begin
    aligned = bus.pc_in[1:0] == 2'b00;
    allow   = 1'b0;
    if (!reset && !bus.flush) begin
      case (state)
        REQ:     allow = count < DEPTH_C;
        // Back-to-back issue needs room for both the returning word and the new one.
        WAIT:    allow = bus.imem_rsp_valid && (count + 1'b1 < DEPTH_C);
        default: allow = 1'b0;
      endcase
    end
    issue      = allow && aligned;
    fault_push = allow && !aligned;
    handshake  = issue && bus.imem_req_ready;
    rsp_push   = !reset && !bus.flush && state == WAIT && bus.imem_rsp_valid;
    head_valid = !reset && count != '0;
    pop        = head_valid && bus.if_ready;
    n_push     = {1'b0, rsp_push} + {1'b0, fault_push};
    wr_next    = wr_ptr + AW'(rsp_push);
  end

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_advance     = handshake;
  assign bus.if_valid       = head_valid;
  assign bus.if_pc          = buf_pc[rd_ptr];
  assign bus.if_instr       = buf_instr[rd_ptr];
  assign bus.if_fault       = buf_fault[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pending_pc <= '0;
      buf_pc     <= '0;
      buf_instr  <= '0;
      buf_fault  <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      case (state)
        WAIT, DROP: state <= bus.imem_rsp_valid ? REQ : DROP;
        default:    state <= REQ;
      endcase
    end else begin
      if (rsp_push) begin
        buf_pc[wr_ptr]    <= pending_pc;
        buf_instr[wr_ptr] <= bus.imem_rsp_data;
        buf_fault[wr_ptr] <= 1'b0;
      end
      // A trap entry lands behind a same-cycle response so program order holds.
      if (fault_push) begin
        buf_pc[wr_next]    <= bus.pc_in;
        buf_instr[wr_next] <= NOP_INSTR;
        buf_fault[wr_next] <= 1'b1;
      end
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      if (handshake) pending_pc <= bus.pc_in;
      case (state)
        REQ:  if (fault_push) state <= FAULT;
              else if (handshake) state <= WAIT;
        WAIT: if (bus.imem_rsp_valid) state <= fault_push ? FAULT : (handshake ? WAIT : REQ);
        DROP: if (bus.imem_rsp_valid) state <= REQ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Fetch unit bench: directed scenarios then random traffic, all outputs checked every
// cycle against a queue-based reference model and a latency-programmable memory.
module tb_instr_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus();
  instr_fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP))
    dut (.clk(clk), .reset(reset), .bus(bus.master));

  typedef struct {logic [31:0] pc; logic [31:0] instr; logic fault;} ent_t;

  int vectors = 0, miscompares = 0;
  ent_t q[$];
  bit busy, discard, trapped;
  logic [31:0] pend;
  bit mem_busy;
  int rem, lat;
  logic [31:0] maddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16]} + 32'h0000_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance the model, then drive memory/PC for the next cycle.
  task automatic step();
    bit allow, exp_req, exp_adv, exp_fault, rsp;
    logic [31:0] pc;
    @(negedge clk);
    rsp = bus.imem_rsp_valid;
    pc  = bus.pc_in;
    allow = 0;
    if (!reset && !bus.flush && !trapped && !discard)
      allow = busy ? (rsp && q.size() + 1 < DEPTH) : (q.size() < DEPTH);
    exp_req   = allow && pc[1:0] == 2'b00;
    exp_adv   = exp_req && bus.imem_req_ready;
    exp_fault = allow && pc[1:0] != 2'b00;
    check("req_valid", bus.imem_req_valid, exp_req);
    check("pc_advance", bus.pc_advance, exp_adv);
    check("req_addr", bus.imem_req_addr, pc);
    check("if_valid", bus.if_valid, !reset && q.size() > 0);
    if (!reset && q.size() > 0) begin
      check("if_pc", bus.if_pc, q[0].pc);
      check("if_instr", bus.if_instr, q[0].instr);
      check("if_fault", bus.if_fault, q[0].fault);
    end
    if (reset) begin
      q.delete(); busy = 0; discard = 0; trapped = 0; pend = '0;
    end else if (bus.flush) begin
      q.delete();
      discard = (busy || discard) && !rsp;
      busy = 0; trapped = 0;
    end else begin
      if (q.size() > 0 && bus.if_ready) void'(q.pop_front());
      if (discard && rsp) discard = 0;
      if (busy && rsp) begin
        q.push_back('{pc: pend, instr: bus.imem_rsp_data, fault: 1'b0});
        busy = 0;
      end
      if (exp_adv) begin busy = 1; pend = pc; end
      if (exp_fault) begin q.push_back('{pc: pc, instr: NOP, fault: 1'b1}); trapped = 1; end
    end
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (reset) begin
      mem_busy = 0;
    end else begin
      if (exp_adv) begin mem_busy = 1; rem = lat; maddr = pc; end
      if (mem_busy) begin
        rem--;
        if (rem == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(maddr);
          mem_busy = 0;
        end
      end
      if (exp_adv) bus.pc_in = bus.pc_in + 32'd4;
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1'b1; bus.flush = 1'b0; bus.pc_in = pc;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lat = 1;
    bus.pc_in = '0; bus.flush = 1'b0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.if_ready = 1'b0;

    // Reset state
    do_reset(32'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_if_fault", bus.if_fault, 1'b0);

    // 1: streaming with single-cycle memory
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1; lat = 1;
    step(); step();
    check("t1_head_pc", bus.if_pc, 32'h0);
    repeat (6) step();

    // 2: decode stalls, buffer fills to two entries, then drains in order
    do_reset(32'h0);
    bus.if_ready = 1'b0;
    repeat (6) step();
    check("t2_full_req", bus.imem_req_valid, 1'b0);
    check("t2_head_pc", bus.if_pc, 32'h0);
    bus.if_ready = 1'b1;
    step();
    check("t2_second_pc", bus.if_pc, 32'h4);
    repeat (6) step();

    // 3: memory not ready holds the request
    do_reset(32'h100);
    bus.imem_req_ready = 1'b0;
    repeat (3) step();
    check("t3_hold_addr", bus.imem_req_addr, 32'h100);
    bus.imem_req_ready = 1'b1;
    repeat (3) step();

    // 4: flush while a 4-cycle fetch is in flight
    do_reset(32'h10);
    lat = 4;
    step();
    bus.flush = 1'b1; bus.pc_in = 32'h200;
    step();
    bus.flush = 1'b0;
    check("t4_empty", bus.if_valid, 1'b0);
    repeat (12) step();

    // 5: flush coincident with the response
    do_reset(32'h300);
    lat = 2;
    step(); step();
    bus.flush = 1'b1; bus.pc_in = 32'h400;
    step();
    bus.flush = 1'b0;
    check("t5_dropped", bus.if_valid, 1'b0);
    repeat (6) step();

    // 6: misaligned PC traps until redirected
    do_reset(32'h102);
    lat = 1; bus.if_ready = 1'b0;
    repeat (3) step();
    check("t6_fault", bus.if_fault, 1'b1);
    check("t6_pc", bus.if_pc, 32'h102);
    check("t6_instr", bus.if_instr, NOP);
    bus.flush = 1'b1; bus.pc_in = 32'h104;
    step();
    bus.flush = 1'b0; bus.if_ready = 1'b1;
    repeat (6) step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      bus.flush = 1'b0;
      if (!discard && ($urandom_range(0, 19) == 0 || (trapped && $urandom_range(0, 3) == 0))) begin
        bus.flush = 1'b1;
        bus.pc_in = {$urandom_range(0, 32'hFFFF), 16'h0} | {16'h0, 14'($urandom()), 2'b00};
        if ($urandom_range(0, 7) == 0) bus.pc_in[1:0] = 2'($urandom_range(1, 3));
      end
      step();
    end
    reset = 1'b0; bus.flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
